// File: rtl/video_stream_framer.sv
// Crops a raw vsync/hsync/strobe camera stream into a framed, linearly addressed active window.
// Optional checkerboard test pattern is enabled by defining VIDEO_FRAMER_PATTERN_EN.
`timescale 1ns/1ps
module video_stream_framer #(
    parameter int H_START  = 10,
    parameter int H_ACTIVE = 702,
    parameter int V_START  = 16,
    parameter int V_ACTIVE = 288,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_vsync,
    input  logic              cam_hsync,
    input  logic              cam_pix_en,
    input  logic [7:0]        cam_data,
`ifdef VIDEO_FRAMER_PATTERN_EN
    input  logic              pattern_on,
`endif
    output logic              video_frame_valid,
    output logic              video_line_valid,
    output logic              video_data_valid,
    output logic [7:0]        video_data,
    output logic [ADDR_W-1:0] video_address,
    output logic [9:0]        frame_count,
    output logic              short_line_err
);

    localparam int H_MAX = (H_ACTIVE > H_START) ? H_ACTIVE : H_START;
    localparam int V_MAX = (V_ACTIVE > V_START) ? V_ACTIVE : V_START;
    // At least 5 bits so the checkerboard can always read bit 4 of column and line.
    localparam int CW = ($clog2(H_MAX + 1) < 5) ? 5 : $clog2(H_MAX + 1);
    localparam int LW = ($clog2(V_MAX + 1) < 5) ? 5 : $clog2(V_MAX + 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [LW-1:0] LINE_ONE = LW'(1);

    typedef enum logic [2:0] {
        WAIT_VS  = 3'd0,
        V_SKIP   = 3'd1,
        H_SKIP   = 3'd2,
        ACTIVE   = 3'd3,
        LINE_END = 3'd4
    } state_t;

    state_t            state_r;
    logic              vs_d_r;
    logic              hs_d_r;
    logic [CW-1:0]     col_r;
    logic [LW-1:0]     line_cnt_r;
    logic [ADDR_W-1:0] addr_base_r;
    logic              vs_edge_s;
    logic              hs_edge_s;
    logic [CW-1:0]     first_col_s;
    logic [7:0]        pixel_s;

    assign vs_edge_s = cam_vsync & ~vs_d_r;
    assign hs_edge_s = cam_hsync & ~hs_d_r;
    // A strobe coincident with hsync is the first skip pixel of the new line.
    assign first_col_s = cam_pix_en ? COL_ONE : {CW{1'b0}};

`ifdef VIDEO_FRAMER_PATTERN_EN
    // Pixel source: 16-px checkerboard or camera luma.
    always_comb begin
        if (pattern_on) begin
            pixel_s = (col_r[4] ^ line_cnt_r[4]) ? 8'd255 : 8'd0;
        end else begin
            pixel_s = cam_data;
        end
    end
`else
    assign pixel_s = cam_data;
`endif

    // Sync history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_d_r <= 1'b0;
            hs_d_r <= 1'b0;
        end else begin
            vs_d_r <= cam_vsync;
            hs_d_r <= cam_hsync;
        end
    end

    // Framing state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r           <= WAIT_VS;
            col_r             <= {CW{1'b0}};
            line_cnt_r        <= {LW{1'b0}};
            addr_base_r       <= {ADDR_W{1'b0}};
            video_frame_valid <= 1'b0;
            video_line_valid  <= 1'b0;
            video_data_valid  <= 1'b0;
            video_data        <= 8'd0;
            video_address     <= {ADDR_W{1'b0}};
            frame_count       <= 10'd0;
            short_line_err    <= 1'b0;
        end else begin
            video_data_valid <= 1'b0;
            if (vs_edge_s) begin
                // vsync wins over everything, including a frame in progress.
                state_r           <= V_SKIP;
                col_r             <= {CW{1'b0}};
                line_cnt_r        <= {LW{1'b0}};
                addr_base_r       <= {ADDR_W{1'b0}};
                short_line_err    <= 1'b0;
                video_frame_valid <= 1'b0;
                video_line_valid  <= 1'b0;
            end else begin
                case (state_r)
                    WAIT_VS: state_r <= WAIT_VS;
                    V_SKIP: begin
                        if (hs_edge_s) begin
                            if (line_cnt_r == LW'(V_START - 1)) begin
                                state_r           <= H_SKIP;
                                video_frame_valid <= 1'b1;
                                line_cnt_r        <= {LW{1'b0}};
                                col_r             <= first_col_s;
                            end else begin
                                line_cnt_r <= line_cnt_r + LINE_ONE;
                            end
                        end
                    end
                    H_SKIP, ACTIVE: begin
                        if (hs_edge_s) begin
                            // Truncated line: keep line bases aligned and treat hsync as next line start.
                            short_line_err   <= 1'b1;
                            video_line_valid <= 1'b0;
                            addr_base_r      <= addr_base_r + ADDR_W'(H_ACTIVE);
                            line_cnt_r       <= line_cnt_r + LINE_ONE;
                            if (line_cnt_r == LW'(V_ACTIVE - 1)) begin
                                video_frame_valid <= 1'b0;
                                frame_count       <= frame_count + 10'd1;
                                state_r           <= WAIT_VS;
                            end else begin
                                col_r   <= first_col_s;
                                state_r <= H_SKIP;
                            end
                        end else if (cam_pix_en && (state_r == H_SKIP)) begin
                            if (col_r == CW'(H_START - 1)) begin
                                state_r          <= ACTIVE;
                                video_line_valid <= 1'b1;
                                col_r            <= {CW{1'b0}};
                            end else begin
                                col_r <= col_r + COL_ONE;
                            end
                        end else if (cam_pix_en) begin
                            video_data_valid <= 1'b1;
                            video_data       <= pixel_s;
                            video_address    <= addr_base_r + ADDR_W'(col_r);
                            if (col_r == CW'(H_ACTIVE - 1)) begin
                                state_r     <= LINE_END;
                                addr_base_r <= addr_base_r + ADDR_W'(H_ACTIVE);
                                line_cnt_r  <= line_cnt_r + LINE_ONE;
                            end else begin
                                col_r <= col_r + COL_ONE;
                            end
                        end
                    end
                    LINE_END: begin
                        video_line_valid <= 1'b0;
                        if (line_cnt_r == LW'(V_ACTIVE)) begin
                            video_frame_valid <= 1'b0;
                            frame_count       <= frame_count + 10'd1;
                            state_r           <= WAIT_VS;
                        end else if (hs_edge_s) begin
                            col_r   <= first_col_s;
                            state_r <= H_SKIP;
                        end
                    end
                    default: begin
                        state_r           <= WAIT_VS;
                        video_frame_valid <= 1'b0;
                        video_line_valid  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_stream_framer.sv
// Directed bench for video_stream_framer: a pixel-event queue model built from the
// framing rules, checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_video_stream_framer;
    localparam int HS = 10;
    localparam int HA = 40;
    localparam int VS = 4;
    localparam int VA = 24;
    localparam int AW = 20;
    localparam int FULL = HS + HA + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_vsync = 1'b0;
    logic          cam_hsync = 1'b0;
    logic          cam_pix_en = 1'b0;
    logic [7:0]    cam_data = 8'd0;
`ifdef VIDEO_FRAMER_PATTERN_EN
    logic          pattern_on = 1'b0;
    bit            m_pat = 1'b0;
`endif
    logic          video_frame_valid;
    logic          video_line_valid;
    logic          video_data_valid;
    logic [7:0]    video_data;
    logic [AW-1:0] video_address;
    logic [9:0]    frame_count;
    logic          short_line_err;

    video_stream_framer #(
        .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cam_vsync(cam_vsync),
        .cam_hsync(cam_hsync),
        .cam_pix_en(cam_pix_en),
        .cam_data(cam_data),
`ifdef VIDEO_FRAMER_PATTERN_EN
        .pattern_on(pattern_on),
`endif
        .video_frame_valid(video_frame_valid),
        .video_line_valid(video_line_valid),
        .video_data_valid(video_data_valid),
        .video_data(video_data),
        .video_address(video_address),
        .frame_count(frame_count),
        .short_line_err(short_line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int addr; int data; } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Frame model state.
    bit m_armed = 1'b0;
    int m_hs = 0;
    bit m_prev_short = 1'b0;
    bit m_err = 1'b0;
    int m_frames = 0;

    // Observations gathered by the compare process.
    int n_pix = 0;
    int last_addr = -1;
    bit grab = 1'b0;
    int grab_addr = -1;
    int lv_rises = 0;
    bit lv_prev = 1'b0;
    bit want = 1'b0;
    int seen_data [HA*VA];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_data(input int col, input int line, input int k);
`ifdef VIDEO_FRAMER_PATTERN_EN
        if (m_pat) return ((((col / 16) + (line / 16)) % 2) == 1) ? 255 : 0;
`endif
        return k % 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_vsync(input bit abort_chk);
        cam_vsync = 1'b1;
        tick();
        m_armed = 1'b1;
        m_hs = 0;
        m_prev_short = 1'b0;
        m_err = 1'b0;
        if (abort_chk) begin
            @(negedge clk);
            check("abort_frame_valid", int'(video_frame_valid), 0);
            check("abort_line_valid", int'(video_line_valid), 0);
        end
        cam_vsync = 1'b0;
        tick();
    endtask

    // One camera line: hsync pulse, then n consecutive strobes with cam_data = strobe index.
    task automatic do_line(input int n);
        int line;
        bit act;
        cam_hsync = 1'b1;
        if (m_armed) begin
            if (m_prev_short) m_err = 1'b1;
            m_hs++;
        end
        tick();
        cam_hsync = 1'b0;
        tick();
        line = m_hs - VS;
        act = m_armed && (m_hs >= VS) && (line < VA);
        for (int k = 0; k < n; k++) begin
            cam_pix_en = 1'b1;
            cam_data = 8'(k);
            if (act && k >= HS && k < HS + HA)
                q.push_back('{cyc + 1, line * HA + (k - HS), exp_data(k - HS, line, k)});
            tick();
        end
        cam_pix_en = 1'b0;
        m_prev_short = act && (n < HS + HA);
        if (act && line == VA - 1 && !m_prev_short) begin
            m_frames++;
            m_armed = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        check("eol_frame_valid", int'(video_frame_valid), int'(m_armed && m_hs >= VS));
        check("eol_line_valid", int'(video_line_valid), int'(act && n >= HS && n < HS + HA));
        check("eol_frame_count", int'(frame_count), m_frames % 1024);
        check("eol_short_err", int'(short_line_err), int'(m_err));
    endtask

    task automatic prefix();
        repeat (VS - 1) do_line(5);
    endtask

    task automatic lines(input int cnt);
        repeat (cnt) do_line(FULL);
    endtask

    // Per-cycle compare of the pixel strobe stream against the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_pixel: got no strobe, expected addr %0d at cycle %0d", q[0].addr, q[0].c);
                void'(q.pop_front());
            end
            want = (q.size() > 0 && q[0].c == cyc);
            check("data_valid", int'(video_data_valid), int'(want));
            check("dv_without_lv", int'(video_data_valid && !video_line_valid), 0);
            check("lv_without_fv", int'(video_line_valid && !video_frame_valid), 0);
            if (video_data_valid && want) begin
                check("address", int'(video_address), q[0].addr);
                check("data", int'(video_data), q[0].data);
                void'(q.pop_front());
            end
            if (video_data_valid) begin
                n_pix++;
                last_addr = int'(video_address);
                if (int'(video_address) < HA * VA) seen_data[int'(video_address)] = int'(video_data);
                if (grab) begin
                    grab_addr = int'(video_address);
                    grab = 1'b0;
                end
            end
            if (video_line_valid && !lv_prev) lv_rises++;
            lv_prev = video_line_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000 ns");
        $fatal(1);
    end

    initial begin
        int k;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame_valid", int'(video_frame_valid), 0);
        check("rst_line_valid", int'(video_line_valid), 0);
        check("rst_data_valid", int'(video_data_valid), 0);
        check("rst_data", int'(video_data), 0);
        check("rst_address", int'(video_address), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_short_err", int'(short_line_err), 0);
        reset = 1'b1;
        tick();

        // Nominal frame.
        n_pix = 0;
        lv_rises = 0;
        do_vsync(1'b0);
        check("start_frame_count", int'(frame_count), 0);
        prefix();
        lines(VA);
        check("nom_pixel_count", n_pix, 960);
        check("nom_last_addr", last_addr, 959);
        check("nom_first_data", seen_data[0], 10);
        check("nom_line1_data", seen_data[40], 10);
        check("nom_last_data", seen_data[959], 49);
        check("nom_frame_count", int'(frame_count), 1);
        check("nom_short_err", int'(short_line_err), 0);
        check("nom_line_rises", lv_rises, 24);

        // Line 5 cut short after 25 active pixels.
        do_vsync(1'b0);
        prefix();
        lines(5);
        do_line(HS + 25);
        grab = 1'b1;
        do_line(FULL);
        check("short_line6_addr", grab_addr, 240);
        check("short_err_set", int'(short_line_err), 1);
        lines(VA - 7);
        check("short_frame_count", int'(frame_count), 2);
        do_vsync(1'b0);
        check("short_err_cleared", int'(short_line_err), 0);

        // Mid-frame vsync after line 10, then a clean frame.
        prefix();
        lines(11);
        do_vsync(1'b1);
        check("abort_frame_count", int'(frame_count), 2);
        prefix();
        grab = 1'b1;
        do_line(FULL);
        check("restart_addr", grab_addr, 0);
        lines(VA - 1);
        check("restart_frame_count", int'(frame_count), 3);

        // Async reset in the middle of an active line.
        do_vsync(1'b0);
        prefix();
        lines(3);
        do_line(HS + 20);
        reset = 1'b0;
        #1;
        check("mid_rst_frame_valid", int'(video_frame_valid), 0);
        check("mid_rst_line_valid", int'(video_line_valid), 0);
        check("mid_rst_data_valid", int'(video_data_valid), 0);
        check("mid_rst_address", int'(video_address), 0);
        check("mid_rst_frame_count", int'(frame_count), 0);
        q.delete();
        m_armed = 1'b0;
        m_hs = 0;
        m_prev_short = 1'b0;
        m_err = 1'b0;
        m_frames = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        k = n_pix;
        repeat (VS + 2) do_line(FULL);
        check("post_rst_no_pixels", n_pix, k);
        do_vsync(1'b0);
        prefix();
        grab = 1'b1;
        lines(VA);
        check("post_rst_first_addr", grab_addr, 0);
        check("post_rst_frame_count", int'(frame_count), 1);

`ifdef VIDEO_FRAMER_PATTERN_EN
        pattern_on = 1'b1;
        m_pat = 1'b1;
        do_vsync(1'b0);
        prefix();
        lines(VA);
        check("pat_l0_c0", seen_data[0], 0);
        check("pat_l0_c15", seen_data[15], 0);
        check("pat_l0_c16", seen_data[16], 255);
        check("pat_l0_c31", seen_data[31], 255);
        check("pat_l16_c0", seen_data[16 * HA], 255);
        pattern_on = 1'b0;
        m_pat = 1'b0;
`endif

        repeat (4) tick();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
